ram_resp: RTL

//   Slave-side responder for the 16-bit word-RAM handshake (stb/we/addr/data_in/data_out/ack)

---
 rtl/ram_resp.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ram_resp.sv
// ram_resp: slave responder for the 16-bit word-RAM handshake.
// Holds a word array, acks each access after a fixed latency and
// inserts periodic refresh stalls that hold off new requests.
module ram_resp #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned RD_LAT     = 3,
    parameter int unsigned WR_LAT     = 2,
    parameter int unsigned REF_PERIOD = 64,
    parameter int unsigned REF_LEN    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [24:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        ack,
    output logic        refreshing
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StRefresh} state_e;

    localparam int unsigned Depth  = 1 << ADDR_BITS;
    localparam int unsigned MaxLat = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned LatW   = (MaxLat > 2) ? $clog2(MaxLat) : 1;
    localparam int unsigned RefW   = $clog2(REF_PERIOD);
    localparam int unsigned RlenW  = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;

    // The acceptance cycle counts as the first latency cycle, so ACCESS lasts LAT-1
    // cycles and lat_q holds the remaining ACCESS cycles minus one. LAT==1 skips ACCESS.
    localparam logic [LatW-1:0]  RdLoad   = LatW'((RD_LAT >= 2) ? RD_LAT - 2 : 0);
    localparam logic [LatW-1:0]  WrLoad   = LatW'((WR_LAT >= 2) ? WR_LAT - 2 : 0);
    localparam bit               RdBypass = (RD_LAT == 1);
    localparam bit               WrBypass = (WR_LAT == 1);
    localparam logic [RefW-1:0]  RefMax   = RefW'(REF_PERIOD - 1);
    localparam logic [RlenW-1:0] RlenLoad = RlenW'(REF_LEN - 1);

    logic [15:0] mem [Depth];

    state_e                 state_q, state_d;
    logic [LatW-1:0]        lat_q, lat_d;
    logic [RlenW-1:0]       rlen_q, rlen_d;
    logic [RefW-1:0]        ref_cnt_q, ref_cnt_d;
    logic                   ref_pend_q, ref_pend_d;
    logic                   ack_q, ack_d;
    logic                   refreshing_q, refreshing_d;
    logic [15:0]            data_out_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   we_q;
    logic [15:0]            data_q;

    logic                   wrap, ref_req, accept, bypass;
    logic                   op_go, op_we, mem_wr, rd_load;
    logic [ADDR_BITS-1:0]   op_addr;
    logic [15:0]            op_data;
    logic                   unused_addr_hi;

    // Upper address bits alias onto the stored words.
    assign unused_addr_hi = ^addr[24:ADDR_BITS];

    assign wrap    = (ref_cnt_q == RefMax);
    // A wrap in the same IDLE cycle as stb already wins over the request.
    assign ref_req = ref_pend_q | wrap;
    assign accept  = (state_q == StIdle) && !ref_req && stb;
    assign bypass  = we ? WrBypass : RdBypass;

    assign data_out   = data_out_q;
    assign ack        = ack_q;
    assign refreshing = refreshing_q;

    // State, latency and refresh bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            lat_q        <= '0;
            rlen_q       <= '0;
            ref_cnt_q    <= '0;
            ref_pend_q   <= 1'b0;
            ack_q        <= 1'b0;
            refreshing_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            rlen_q       <= rlen_d;
            ref_cnt_q    <= ref_cnt_d;
            ref_pend_q   <= ref_pend_d;
            ack_q        <= ack_d;
            refreshing_q <= refreshing_d;
        end
    end

    // Next-state logic for the access/refresh sequencer.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        rlen_d     = rlen_q;
        ref_cnt_d  = wrap ? '0 : ref_cnt_q + 1'b1;
        ref_pend_d = ref_pend_q | wrap;
        unique case (state_q)
            StIdle: begin
                if (ref_req) begin
                    state_d    = StRefresh;
                    rlen_d     = RlenLoad;
                    ref_pend_d = 1'b0;
                end else if (stb) begin
                    if (bypass) begin
                        state_d = StDone;
                    end else begin
                        state_d = StAccess;
                        lat_d   = we ? WrLoad : RdLoad;
                    end
                end
            end
            StAccess: begin
                if (!stb) begin
                    state_d = StIdle;
                end else if (lat_q == '0) begin
                    state_d = StDone;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StRefresh: begin
                if (rlen_q == '0) begin
                    state_d = StIdle;
                end else begin
                    rlen_d = rlen_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output and memory-operation decode; the op fires on the edge entering DONE.
    always_comb begin
        op_go = (state_d == StDone);
        if (state_q == StIdle) begin
            op_we   = we;
            op_addr = addr[ADDR_BITS-1:0];
            op_data = data_in;
        end else begin
            op_we   = we_q;
            op_addr = addr_q;
            op_data = data_q;
        end
        // Reset on the completing edge discards a pending write.
        mem_wr       = op_go && op_we && !rst;
        rd_load      = op_go && !op_we;
        ack_d        = op_go;
        refreshing_d = (state_d == StRefresh);
    end

    // Request capture at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= addr[ADDR_BITS-1:0];
            we_q   <= we;
            data_q <= data_in;
        end
    end

    // Word array write port (no reset, contents survive rst).
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[op_addr] <= op_data;
        end
    end

    // Read data register, held until the next read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
        end else if (rd_load) begin
            data_out_q <= mem[op_addr];
        end
    end

endmodule
